// File: rtl/ir_seguidor_fsm_pkg.sv
// ============================================================================
// ir_seguidor_fsm_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the line-follower decision stage:
//   - motor command codes sent to the PWM motor driver
//   - FSM state encoding (3 bit)
//   - IR sensor pattern constants, ordered {izq, cen, der}
//   - helper that classifies a filtered sensor pattern
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

package ir_seguidor_fsm_pkg;

  // Motor command codes. Codes 6 and 7 are never issued.
  typedef enum logic [2:0] {
    CMD_STOP   = 3'd0,
    CMD_FWD    = 3'd1,
    CMD_LEFT   = 3'd2,
    CMD_RIGHT  = 3'd3,
    CMD_SPIN_L = 3'd4,
    CMD_SPIN_R = 3'd5
  } motor_cmd_e;

  // Decision FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_SEARCH = 3'd2,
    ST_CROSS  = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Side on which the line was last seen; selects the spin direction
  // used while searching for a lost line.
  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_e;

  // Classification of the filtered pattern.
  typedef enum logic [2:0] {
    DEC_FWD   = 3'd0,
    DEC_LEFT  = 3'd1,
    DEC_RIGHT = 3'd2,
    DEC_CROSS = 3'd3,
    DEC_LOST  = 3'd4,
    DEC_HOLD  = 3'd5
  } decode_e;

  // Sensor patterns {izq, cen, der}; 1 = line under the sensor.
  // 3'b101 (line on both sides but not centre) is physically meaningless
  // and decodes to DEC_HOLD.
  localparam logic [2:0] PAT_FWD     = 3'b010;
  localparam logic [2:0] PAT_LEFT_A  = 3'b110;
  localparam logic [2:0] PAT_LEFT_B  = 3'b100;
  localparam logic [2:0] PAT_RIGHT_A = 3'b011;
  localparam logic [2:0] PAT_RIGHT_B = 3'b001;
  localparam logic [2:0] PAT_CROSS   = 3'b111;
  localparam logic [2:0] PAT_LOST    = 3'b000;

  function automatic decode_e ir_decode(input logic [2:0] pat);
    decode_e d;
    case (pat)
      PAT_FWD:                 d = DEC_FWD;
      PAT_LEFT_A, PAT_LEFT_B:  d = DEC_LEFT;
      PAT_RIGHT_A, PAT_RIGHT_B: d = DEC_RIGHT;
      PAT_CROSS:               d = DEC_CROSS;
      PAT_LOST:                d = DEC_LOST;
      default:                 d = DEC_HOLD;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ir_seguidor_fsm_if.sv
// ============================================================================
// ir_seguidor_fsm_if
// ----------------------------------------------------------------------------
// Valid/ready command channel from the decision stage to the motor driver.
//   motor_cmd  [2:0]  command code, stable while cmd_valid && !cmd_ready
//   cmd_valid         command present
//   cmd_ready         driver accepts the command this cycle
// master = decision stage, slave = motor driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

interface ir_seguidor_fsm_if;
  logic [2:0] motor_cmd;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output motor_cmd, output cmd_valid, input cmd_ready);
  modport slave  (input motor_cmd, input cmd_valid, output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/ir_seguidor_fsm_filtro.sv
// ============================================================================
// ir_seguidor_fsm_filtro
// ----------------------------------------------------------------------------
// Two-flop synchroniser plus stability filter for a WIDTH-bit vector.
// The output follows the synchronised vector only after it has held the
// same value for STABLE_CYCLES consecutive cycles; any change restarts the
// count. Latency raw_i -> filt_o is 2 + STABLE_CYCLES clock cycles.
// Ports:
//   clk     in          system clock
//   rst_n   in          asynchronous reset, active low
//   raw_i   in  WIDTH   asynchronous input vector
//   filt_o  out WIDTH   filtered vector (reset value 0)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module ir_seguidor_fsm_filtro #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] filt_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] filt_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // cnt_d is the number of consecutive cycles sync2_q has shown its current
  // value, including the present one; it saturates at STABLE_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != cand_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      cnt_q   <= cnt_d;
      if (cnt_d >= CW'(STABLE_CYCLES)) begin
        filt_q <= sync2_q;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

`default_nettype wire

// File: rtl/ir_seguidor_fsm.sv
// ============================================================================
// ir_seguidor_fsm
// ----------------------------------------------------------------------------
// Line-follower decision stage. Filters the three IR channels, runs a
// follow/search/cross/halt FSM and issues motor commands over a valid/ready
// channel.
// Ports:
//   clk            in      system clock
//   rst_n          in      asynchronous reset, active low
//   en_i           in      run enable; 0 forces IDLE / STOP
//   ir_izq_i       in      left sensor, 1 = line
//   ir_cen_i       in      centre sensor, 1 = line
//   ir_der_i       in      right sensor, 1 = line
//   cmd_if         master  motor_cmd / cmd_valid / cmd_ready channel
//   line_lost_o    out     high while in SEARCH (registered, +1 cycle)
//   halted_o       out     high while in HALT (registered, +1 cycle)
//   cross_count_o  out 8   intersections passed, wraps 255 -> 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module ir_seguidor_fsm
  import ir_seguidor_fsm_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int LOST_TIMEOUT  = 5000000,
  parameter int CROSS_CYCLES  = 2000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     ir_izq_i,
  input  logic                     ir_cen_i,
  input  logic                     ir_der_i,
  ir_seguidor_fsm_if.master        cmd_if,
  output logic                     line_lost_o,
  output logic                     halted_o,
  output logic [7:0]               cross_count_o
);

  // One timer serves SEARCH and CROSS, which are mutually exclusive.
  localparam int TMAX = (LOST_TIMEOUT > CROSS_CYCLES) ? LOST_TIMEOUT : CROSS_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  logic [2:0]  pat_w;
  decode_e     dec_w;
  motor_cmd_e  spin_w;

  state_e      state_q;
  motor_cmd_e  desired_q;
  turn_e       last_turn_q;
  logic [TW-1:0] timer_q;
  logic [7:0]  cross_q;
  logic        line_lost_q;
  logic        halted_q;

  motor_cmd_e  last_sent_q;
  logic [2:0]  motor_cmd_q;
  logic        cmd_valid_q;
  logic        diff_w;
  logic        can_load_w;

  ir_seguidor_fsm_filtro #(
    .WIDTH         (3),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filtro (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  ({ir_izq_i, ir_cen_i, ir_der_i}),
    .filt_o (pat_w)
  );

  assign dec_w  = ir_decode(pat_w);
  assign spin_w = (last_turn_q == TURN_LEFT) ? CMD_SPIN_L : CMD_SPIN_R;

  // Decision FSM. desired_q is written together with the state change so
  // that a pattern change reaches the issue register one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      desired_q   <= CMD_STOP;
      last_turn_q <= TURN_LEFT;
      timer_q     <= '0;
      cross_q     <= '0;
      line_lost_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      line_lost_q <= (state_q == ST_SEARCH);
      halted_q    <= (state_q == ST_HALT);
      if (!en_i) begin
        state_q   <= ST_IDLE;
        desired_q <= CMD_STOP;
        timer_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            desired_q <= CMD_STOP;
            state_q   <= ST_FOLLOW;
          end
          ST_FOLLOW: begin
            case (dec_w)
              DEC_FWD: desired_q <= CMD_FWD;
              DEC_LEFT: begin
                desired_q   <= CMD_LEFT;
                last_turn_q <= TURN_LEFT;
              end
              DEC_RIGHT: begin
                desired_q   <= CMD_RIGHT;
                last_turn_q <= TURN_RIGHT;
              end
              DEC_CROSS: begin
                state_q   <= ST_CROSS;
                desired_q <= CMD_FWD;
                timer_q   <= '0;
                cross_q   <= cross_q + 8'd1;
              end
              DEC_LOST: begin
                state_q   <= ST_SEARCH;
                desired_q <= spin_w;
                timer_q   <= '0;
              end
              default: ; // 3'b101: keep previous command
            endcase
          end
          ST_SEARCH: begin
            if (dec_w != DEC_LOST) begin
              state_q <= ST_FOLLOW;
            end else if (timer_q == TW'(LOST_TIMEOUT - 1)) begin
              state_q   <= ST_HALT;
              desired_q <= CMD_STOP;
            end else begin
              timer_q   <= timer_q + 1'b1;
              desired_q <= spin_w;
            end
          end
          ST_CROSS: begin
            desired_q <= CMD_FWD;
            if (timer_q == TW'(CROSS_CYCLES - 1)) begin
              state_q <= ST_FOLLOW;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ST_HALT: desired_q <= CMD_STOP;
          default: begin
            state_q   <= ST_IDLE;
            desired_q <= CMD_STOP;
          end
        endcase
      end
    end
  end

  // Command issue. last_sent_q tracks the most recently loaded command, so
  // while the driver stalls only the newest desired value survives.
  assign diff_w     = (desired_q != last_sent_q);
  assign can_load_w = !cmd_valid_q || cmd_if.cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sent_q <= CMD_STOP;
      motor_cmd_q <= CMD_STOP;
      cmd_valid_q <= 1'b0;
    end else if (diff_w && can_load_w) begin
      last_sent_q <= desired_q;
      motor_cmd_q <= desired_q;
      cmd_valid_q <= 1'b1;
    end else if (cmd_valid_q && cmd_if.cmd_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

  assign cmd_if.motor_cmd = motor_cmd_q;
  assign cmd_if.cmd_valid = cmd_valid_q;
  assign line_lost_o      = line_lost_q;
  assign halted_o         = halted_q;
  assign cross_count_o    = cross_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_seguidor_fsm.sv
// ============================================================================
// tb_ir_seguidor_fsm
// ----------------------------------------------------------------------------
// Directed self-checking bench for ir_seguidor_fsm with
// STABLE_CYCLES=4, LOST_TIMEOUT=20, CROSS_CYCLES=10.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module tb_ir_seguidor_fsm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ir_izq, ir_cen, ir_der;
  logic       line_lost, halted;
  logic [7:0] cross_count;
  int         n_checks;
  int         n_fail;

  ir_seguidor_fsm_if cmd_if ();

  ir_seguidor_fsm #(
    .STABLE_CYCLES (4),
    .LOST_TIMEOUT  (20),
    .CROSS_CYCLES  (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en),
    .ir_izq_i      (ir_izq),
    .ir_cen_i      (ir_cen),
    .ir_der_i      (ir_der),
    .cmd_if        (cmd_if),
    .line_lost_o   (line_lost),
    .halted_o      (halted),
    .cross_count_o (cross_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pins(input logic [2:0] p);
    {ir_izq, ir_cen, ir_der} = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; set_pins(3'b000); cmd_if.cmd_ready = 1'b1;
    tick(3);
    n_checks++; if (cmd_if.motor_cmd !== 3'd0) begin n_fail++; $display("FAIL reset_motor_cmd: got %0d expected 0", cmd_if.motor_cmd); end
    n_checks++; if (cmd_if.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %0b expected 0", cmd_if.cmd_valid); end
    n_checks++; if (line_lost !== 1'b0) begin n_fail++; $display("FAIL reset_line_lost: got %0b expected 0", line_lost); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    n_checks++; if (cross_count !== 8'd0) begin n_fail++; $display("FAIL reset_cross_count: got %0d expected 0", cross_count); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_follow_latency();
    logic early;
    // Settle on LEFT first so FOLLOW never sees the empty pattern.
    set_pins(3'b110);
    tick(10);
    en = 1'b1;
    tick(6);
    n_checks++; if (cmd_if.motor_cmd !== 3'd2) begin n_fail++; $display("FAIL initial_left: got %0d expected 2", cmd_if.motor_cmd); end
    set_pins(3'b010);
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (cmd_if.cmd_valid !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL fwd_latency_early: got valid before cycle 8 expected none"); end
    tick(1);
    n_checks++; if (cmd_if.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_latency_valid: got %0b expected 1", cmd_if.cmd_valid); end
    n_checks++; if (cmd_if.motor_cmd !== 3'd1) begin n_fail++; $display("FAIL fwd_latency_cmd: got %0d expected 1", cmd_if.motor_cmd); end
  endtask

  task automatic test_glitch();
    logic bad;
    tick(3);
    bad = 1'b0;
    set_pins(3'b110);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (cmd_if.motor_cmd !== 3'd1 || cmd_if.cmd_valid !== 1'b0) bad = 1'b1;
    end
    set_pins(3'b010);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (cmd_if.motor_cmd !== 3'd1 || cmd_if.cmd_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL glitch_filtered: got command change expected motor_cmd 1 steady"); end
    set_pins(3'b110);
    tick(10);
    n_checks++; if (cmd_if.motor_cmd !== 3'd2) begin n_fail++; $display("FAIL glitch_held_left: got %0d expected 2", cmd_if.motor_cmd); end
  endtask

  task automatic test_search_halt();
    set_pins(3'b000);
    tick(9);
    n_checks++; if (cmd_if.motor_cmd !== 3'd4) begin n_fail++; $display("FAIL search_spin_l: got %0d expected 4", cmd_if.motor_cmd); end
    n_checks++; if (line_lost !== 1'b1) begin n_fail++; $display("FAIL search_line_lost: got %0b expected 1", line_lost); end
    tick(17);
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL search_not_yet_halted: got %0b expected 0", halted); end
    tick(2);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %0b expected 1", halted); end
    n_checks++; if (cmd_if.motor_cmd !== 3'd0) begin n_fail++; $display("FAIL halt_stop: got %0d expected 0", cmd_if.motor_cmd); end
    n_checks++; if (line_lost !== 1'b0) begin n_fail++; $display("FAIL halt_line_lost_clear: got %0b expected 0", line_lost); end
    set_pins(3'b010);
    tick(12);
    n_checks++; if (halted !== 1'b1 || cmd_if.motor_cmd !== 3'd0) begin n_fail++; $display("FAIL halt_sticky: got halted %0b cmd %0d expected 1 and 0", halted, cmd_if.motor_cmd); end
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(4);
    n_checks++; if (cmd_if.motor_cmd !== 3'd1 || halted !== 1'b0) begin n_fail++; $display("FAIL restart_fwd: got cmd %0d halted %0b expected 1 and 0", cmd_if.motor_cmd, halted); end
  endtask

  task automatic test_cross();
    set_pins(3'b111);
    tick(7);
    set_pins(3'b011);
    tick(1);
    n_checks++; if (cross_count !== 8'd1) begin n_fail++; $display("FAIL cross_count_one: got %0d expected 1", cross_count); end
    tick(10);
    n_checks++; if (cmd_if.motor_cmd !== 3'd1) begin n_fail++; $display("FAIL cross_forced_fwd: got %0d expected 1", cmd_if.motor_cmd); end
    tick(1);
    n_checks++; if (cmd_if.motor_cmd !== 3'd3) begin n_fail++; $display("FAIL cross_then_right: got %0d expected 3", cmd_if.motor_cmd); end
    // Held 111 re-enters CROSS every 11 cycles; crossing #256 lands at cycle 2801.
    set_pins(3'b111);
    tick(2800);
    n_checks++; if (cross_count !== 8'd255) begin n_fail++; $display("FAIL cross_count_255: got %0d expected 255", cross_count); end
    tick(1);
    n_checks++; if (cross_count !== 8'd0) begin n_fail++; $display("FAIL cross_count_wrap: got %0d expected 0", cross_count); end
  endtask

  task automatic test_back_to_back();
    logic bad;
    set_pins(3'b011);
    tick(30);
    n_checks++; if (cmd_if.motor_cmd !== 3'd3) begin n_fail++; $display("FAIL bp_start_right: got %0d expected 3", cmd_if.motor_cmd); end
    cmd_if.cmd_ready = 1'b0;
    set_pins(3'b010);
    tick(8);
    n_checks++; if (cmd_if.motor_cmd !== 3'd1 || cmd_if.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_fwd_pending: got cmd %0d valid %0b expected 1 and 1", cmd_if.motor_cmd, cmd_if.cmd_valid); end
    bad = 1'b0;
    set_pins(3'b110);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cmd_if.motor_cmd !== 3'd1 || cmd_if.cmd_valid !== 1'b1) bad = 1'b1;
    end
    set_pins(3'b011);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cmd_if.motor_cmd !== 3'd1 || cmd_if.cmd_valid !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL bp_cmd_stable: got change while stalled expected cmd 1 valid 1"); end
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    n_checks++; if (cmd_if.motor_cmd !== 3'd3 || cmd_if.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_latest_wins: got cmd %0d valid %0b expected 3 and 1", cmd_if.motor_cmd, cmd_if.cmd_valid); end
    tick(1);
    n_checks++; if (cmd_if.cmd_valid !== 1'b0 || cmd_if.motor_cmd !== 3'd3) begin n_fail++; $display("FAIL bp_drain: got cmd %0d valid %0b expected 3 and 0", cmd_if.motor_cmd, cmd_if.cmd_valid); end
  endtask

  task automatic test_async_reset();
    cmd_if.cmd_ready = 1'b0;
    set_pins(3'b000);
    tick(10);
    n_checks++; if (line_lost !== 1'b1 || cmd_if.cmd_valid !== 1'b1 || cmd_if.motor_cmd !== 3'd5) begin n_fail++; $display("FAIL pre_reset_search: got lost %0b valid %0b cmd %0d expected 1 1 5", line_lost, cmd_if.cmd_valid, cmd_if.motor_cmd); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (cmd_if.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL async_cmd_valid: got %0b expected 0", cmd_if.cmd_valid); end
    n_checks++; if (cmd_if.motor_cmd !== 3'd0) begin n_fail++; $display("FAIL async_motor_cmd: got %0d expected 0", cmd_if.motor_cmd); end
    n_checks++; if (line_lost !== 1'b0) begin n_fail++; $display("FAIL async_line_lost: got %0b expected 0", line_lost); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL async_halted: got %0b expected 0", halted); end
    n_checks++; if (cross_count !== 8'd0) begin n_fail++; $display("FAIL async_cross_count: got %0d expected 0", cross_count); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_follow_latency();
    test_glitch();
    test_search_halt();
    test_cross();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
